tlb_pipe: RTL

- Parametrised next-generation fully-associative LoongArch TLB for the myCPU core.
- Provides two search ports (fetch / load-store) with a registered, 1-cycle-latency result, plus write, read and INVTLB operations.
- INVTLB takes dedicated ASID/VA operands instead of borrowing search port 1.
- Adds a free-running random-replacement index for TLBFILL and an error flag for illegal INVTLB opcodes.

---
 rtl/tlb_pipe_if.sv | 119 +++++++++++
 rtl/tlb_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_pipe_if.sv
// Bus bundle for tlb_pipe: two search ports, INVTLB, write, read and fill index.
// TLB_MULTIHIT_CHECK_EN adds s0_multihit / s1_multihit.
interface tlb_pipe_if #(
  parameter int unsigned TLBNUM = 16
);
  localparam int unsigned IDXW = $clog2(TLBNUM);

  logic            s0_req;
  logic [18:0]     s0_vppn;
  logic            s0_va_bit12;
  logic [9:0]      s0_asid;
  logic            s0_rvalid;
  logic            s0_found;
  logic [IDXW-1:0] s0_index;
  logic [19:0]     s0_ppn;
  logic [5:0]      s0_ps;
  logic [1:0]      s0_plv;
  logic [1:0]      s0_mat;
  logic            s0_d;
  logic            s0_v;

  logic            s1_req;
  logic [18:0]     s1_vppn;
  logic            s1_va_bit12;
  logic [9:0]      s1_asid;
  logic            s1_rvalid;
  logic            s1_found;
  logic [IDXW-1:0] s1_index;
  logic [19:0]     s1_ppn;
  logic [5:0]      s1_ps;
  logic [1:0]      s1_plv;
  logic [1:0]      s1_mat;
  logic            s1_d;
  logic            s1_v;

  logic            invtlb_valid;
  logic [4:0]      invtlb_op;
  logic [9:0]      invtlb_asid;
  logic [18:0]     invtlb_vppn;
  logic            invtlb_err;

  logic            we;
  logic [IDXW-1:0] w_index;
  logic            w_e;
  logic [5:0]      w_ps;
  logic [18:0]     w_vppn;
  logic [9:0]      w_asid;
  logic            w_g;
  logic [19:0]     w_ppn0;
  logic [1:0]      w_plv0;
  logic [1:0]      w_mat0;
  logic            w_d0;
  logic            w_v0;
  logic [19:0]     w_ppn1;
  logic [1:0]      w_plv1;
  logic [1:0]      w_mat1;
  logic            w_d1;
  logic            w_v1;

  logic [IDXW-1:0] fill_index;

  logic [IDXW-1:0] r_index;
  logic            r_e;
  logic [18:0]     r_vppn;
  logic [5:0]      r_ps;
  logic [9:0]      r_asid;
  logic            r_g;
  logic [19:0]     r_ppn0;
  logic [1:0]      r_plv0;
  logic [1:0]      r_mat0;
  logic            r_d0;
  logic            r_v0;
  logic [19:0]     r_ppn1;
  logic [1:0]      r_plv1;
  logic [1:0]      r_mat1;
  logic            r_d1;
  logic            r_v1;

`ifdef TLB_MULTIHIT_CHECK_EN
  logic            s0_multihit;
  logic            s1_multihit;
`endif

  modport master (
    output s0_req, s0_vppn, s0_va_bit12, s0_asid,
    input  s0_rvalid, s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
    output s1_req, s1_vppn, s1_va_bit12, s1_asid,
    input  s1_rvalid, s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
    output invtlb_valid, invtlb_op, invtlb_asid, invtlb_vppn,
    input  invtlb_err,
    output we, w_index, w_e, w_ps, w_vppn, w_asid, w_g,
    output w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
    input  fill_index,
    output r_index,
    input  r_e, r_vppn, r_ps, r_asid, r_g,
    input  r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1
`ifdef TLB_MULTIHIT_CHECK_EN
    , input s0_multihit, s1_multihit
`endif
  );

  modport slave (
    input  s0_req, s0_vppn, s0_va_bit12, s0_asid,
    output s0_rvalid, s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
    input  s1_req, s1_vppn, s1_va_bit12, s1_asid,
    output s1_rvalid, s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
    input  invtlb_valid, invtlb_op, invtlb_asid, invtlb_vppn,
    output invtlb_err,
    input  we, w_index, w_e, w_ps, w_vppn, w_asid, w_g,
    input  w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
    output fill_index,
    input  r_index,
    output r_e, r_vppn, r_ps, r_asid, r_g,
    output r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1
`ifdef TLB_MULTIHIT_CHECK_EN
    , output s0_multihit, s1_multihit
`endif
  );
endinterface

// File: rtl/tlb_pipe.sv
// Fully-associative LoongArch TLB: two registered search ports, write/read, INVTLB, fill index.
// Optional TLB_MULTIHIT_CHECK_EN adds registered per-port multi-hit flags.
module tlb_pipe #(
  parameter int unsigned TLBNUM = 16
) (
  input  logic       clk,
  input  logic       resetn,
  tlb_pipe_if.slave  bus
);
  localparam int unsigned IDXW = $clog2(TLBNUM);
  localparam int unsigned NP   = 2;

  typedef struct packed {
    logic        g;
    logic        ps4m;
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] index;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [1:0]      plv;
    logic [1:0]      mat;
    logic            d;
    logic            v;
  } srch_res_t;

  logic [TLBNUM-1:0] e_q;
  tlb_entry_t        ent_q [TLBNUM];
  tlb_entry_t        w_ent_c;
  logic [IDXW-1:0]   fill_q;
  logic              err_q;
  logic [TLBNUM-1:0] inv_c;
  logic              op_bad_c;

  logic [NP-1:0]     req_c;
  logic [NP-1:0]     b12_c;
  logic [18:0]       vppn_c [NP];
  logic [9:0]        asid_c [NP];
  logic [TLBNUM-1:0] hit_c  [NP];
  srch_res_t         res_d  [NP];
  srch_res_t         res_q  [NP];
  logic [NP-1:0]     rvalid_q;

  // 4MB pages ignore vppn[9:0]; 4KB pages compare the full VPPN
  function automatic logic va_eq(tlb_entry_t en, logic [18:0] vppn);
    return (en.vppn[18:10] == vppn[18:10]) && (en.ps4m || (en.vppn[9:0] == vppn[9:0]));
  endfunction

  function automatic srch_res_t pick(tlb_entry_t en, logic [18:0] vppn, logic b12,
                                     logic [IDXW-1:0] idx);
    srch_res_t r;
    logic      odd;
    odd     = en.ps4m ? vppn[9] : b12;
    r.found = 1'b1;
    r.index = idx;
    r.ps    = en.ps4m ? 6'd22 : 6'd12;
    r.ppn   = odd ? en.ppn1 : en.ppn0;
    r.plv   = odd ? en.plv1 : en.plv0;
    r.mat   = odd ? en.mat1 : en.mat0;
    r.d     = odd ? en.d1   : en.d0;
    r.v     = odd ? en.v1   : en.v0;
    return r;
  endfunction

  function automatic logic inv_sel(tlb_entry_t en, logic [4:0] op, logic [9:0] asid,
                                   logic [18:0] vppn);
    logic asid_eq;
    asid_eq = (en.asid == asid);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return en.g;
      5'd3:       return !en.g;
      5'd4:       return !en.g && asid_eq;
      5'd5:       return !en.g && asid_eq && va_eq(en, vppn);
      5'd6:       return (en.g || asid_eq) && va_eq(en, vppn);
      default:    return 1'b0;
    endcase
  endfunction

  assign req_c     = {bus.s1_req, bus.s0_req};
  assign b12_c     = {bus.s1_va_bit12, bus.s0_va_bit12};
  assign vppn_c[0] = bus.s0_vppn;
  assign vppn_c[1] = bus.s1_vppn;
  assign asid_c[0] = bus.s0_asid;
  assign asid_c[1] = bus.s1_asid;

  // Match vectors and lowest-index priority select per search port
  always_comb begin
    for (int p = 0; p < int'(NP); p++) begin
      hit_c[p]    = '0;
      res_d[p]    = '0;
      res_d[p].ps = 6'd12;
      for (int j = 0; j < int'(TLBNUM); j++) begin
        hit_c[p][j] = e_q[j] && va_eq(ent_q[j], vppn_c[p]) &&
                      (ent_q[j].g || (ent_q[j].asid == asid_c[p]));
      end
      for (int j = int'(TLBNUM) - 1; j >= 0; j--) begin
        if (hit_c[p][j]) res_d[p] = pick(ent_q[j], vppn_c[p], b12_c[p], IDXW'(j));
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid_q <= '0;
      for (int p = 0; p < int'(NP); p++) res_q[p] <= '0;
    end else begin
      rvalid_q <= req_c;
      for (int p = 0; p < int'(NP); p++) begin
        if (req_c[p]) res_q[p] <= res_d[p];
      end
    end
  end

`ifdef TLB_MULTIHIT_CHECK_EN
  logic [NP-1:0] multi_d;
  logic [NP-1:0] multi_q;

  // More than one bit set: x & (x-1) is non-zero
  always_comb begin
    for (int p = 0; p < int'(NP); p++) begin
      multi_d[p] = |(hit_c[p] & (hit_c[p] - TLBNUM'(1)));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      multi_q <= '0;
    end else begin
      for (int p = 0; p < int'(NP); p++) begin
        if (req_c[p]) multi_q[p] <= multi_d[p];
      end
    end
  end

  assign bus.s0_multihit = multi_q[0];
  assign bus.s1_multihit = multi_q[1];
`endif

  always_comb begin
    op_bad_c = (bus.invtlb_op > 5'd6);
    inv_c    = '0;
    for (int j = 0; j < int'(TLBNUM); j++) begin
      inv_c[j] = inv_sel(ent_q[j], bus.invtlb_op, bus.invtlb_asid, bus.invtlb_vppn);
    end
  end

  always_comb begin
    w_ent_c      = '0;
    w_ent_c.g    = bus.w_g;
    w_ent_c.ps4m = (bus.w_ps == 6'd22);
    w_ent_c.vppn = bus.w_vppn;
    w_ent_c.asid = bus.w_asid;
    w_ent_c.ppn0 = bus.w_ppn0;
    w_ent_c.plv0 = bus.w_plv0;
    w_ent_c.mat0 = bus.w_mat0;
    w_ent_c.d0   = bus.w_d0;
    w_ent_c.v0   = bus.w_v0;
    w_ent_c.ppn1 = bus.w_ppn1;
    w_ent_c.plv1 = bus.w_plv1;
    w_ent_c.mat1 = bus.w_mat1;
    w_ent_c.d1   = bus.w_d1;
    w_ent_c.v1   = bus.w_v1;
  end

  // INVTLB wins over a same-cycle write, which is discarded
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q    <= '0;
      err_q  <= 1'b0;
      fill_q <= '0;
    end else begin
      err_q  <= bus.invtlb_valid && op_bad_c;
      fill_q <= fill_q + IDXW'(1);
      if (bus.invtlb_valid) begin
        e_q <= e_q & ~inv_c;
      end else if (bus.we) begin
        e_q[bus.w_index] <= bus.w_e;
      end
    end
  end

  // Entry payload needs no reset: E gates every use
  always_ff @(posedge clk) begin
    if (bus.we && !bus.invtlb_valid) ent_q[bus.w_index] <= w_ent_c;
  end

  assign bus.s0_rvalid  = rvalid_q[0];
  assign bus.s0_found   = res_q[0].found;
  assign bus.s0_index   = res_q[0].index;
  assign bus.s0_ppn     = res_q[0].ppn;
  assign bus.s0_ps      = res_q[0].ps;
  assign bus.s0_plv     = res_q[0].plv;
  assign bus.s0_mat     = res_q[0].mat;
  assign bus.s0_d       = res_q[0].d;
  assign bus.s0_v       = res_q[0].v;
  assign bus.s1_rvalid  = rvalid_q[1];
  assign bus.s1_found   = res_q[1].found;
  assign bus.s1_index   = res_q[1].index;
  assign bus.s1_ppn     = res_q[1].ppn;
  assign bus.s1_ps      = res_q[1].ps;
  assign bus.s1_plv     = res_q[1].plv;
  assign bus.s1_mat     = res_q[1].mat;
  assign bus.s1_d       = res_q[1].d;
  assign bus.s1_v       = res_q[1].v;
  assign bus.invtlb_err = err_q;
  assign bus.fill_index = fill_q;

  assign bus.r_e    = e_q[bus.r_index];
  assign bus.r_vppn = ent_q[bus.r_index].vppn;
  assign bus.r_ps   = ent_q[bus.r_index].ps4m ? 6'd22 : 6'd12;
  assign bus.r_asid = ent_q[bus.r_index].asid;
  assign bus.r_g    = ent_q[bus.r_index].g;
  assign bus.r_ppn0 = ent_q[bus.r_index].ppn0;
  assign bus.r_plv0 = ent_q[bus.r_index].plv0;
  assign bus.r_mat0 = ent_q[bus.r_index].mat0;
  assign bus.r_d0   = ent_q[bus.r_index].d0;
  assign bus.r_v0   = ent_q[bus.r_index].v0;
  assign bus.r_ppn1 = ent_q[bus.r_index].ppn1;
  assign bus.r_plv1 = ent_q[bus.r_index].plv1;
  assign bus.r_mat1 = ent_q[bus.r_index].mat1;
  assign bus.r_d1   = ent_q[bus.r_index].d1;
  assign bus.r_v1   = ent_q[bus.r_index].v1;
endmodule
